// File: rtl/cordic_cos_fixed.sv
// Iterative rotation-mode CORDIC producing cos(angle) as sign-magnitude {sign, 1 int bit, 19 frac bits}.
// Valid/ready on both sides, one micro-rotation per clock; feeds the fixed-point -> IEEE-754 converter.
module cordic_cos_fixed #(
    parameter int unsigned ITER = 16,
    parameter int unsigned W    = 24
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [21:0] angle_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic        sign_o,
    output logic        integer_o,
    output logic [18:0] fractional_o
);

    typedef enum logic [1:0] {
        IDLE,
        ROTATE,
        DONE
    } state_t;

    localparam int unsigned SH     = 32 - W;
    localparam int unsigned D      = W - 21;
    localparam logic [4:0]  ITER_C = 5'(ITER);
    localparam logic [32:0] K_RND  = ({32'h26DD3B6A, 1'b0} + (33'd1 << SH)) >> (SH + 1);
    localparam logic [W-1:0] K_W   = W'(K_RND);
    localparam logic [W:0]  HALF   = (W + 1)'(1) << (D - 1);

    function automatic logic [W-1:0] atan_w(input logic [4:0] i);
        logic [31:0] a;
        case (i)
            5'd0:    a = 32'h3243F6A8;
            5'd1:    a = 32'h1DAC6705;
            5'd2:    a = 32'h0FADBAFC;
            5'd3:    a = 32'h07F56EA6;
            5'd4:    a = 32'h03FEAB76;
            5'd5:    a = 32'h01FFD55B;
            5'd6:    a = 32'h00FFFAAA;
            5'd7:    a = 32'h007FFF55;
            5'd8:    a = 32'h003FFFEA;
            5'd9:    a = 32'h001FFFFD;
            5'd10:   a = 32'h000FFFFF;
            5'd11:   a = 32'h0007FFFF;
            5'd12:   a = 32'h0003FFFF;
            5'd13:   a = 32'h0001FFFF;
            5'd14:   a = 32'h0000FFFF;
            5'd15:   a = 32'h00007FFF;
            5'd16:   a = 32'h00003FFF;
            5'd17:   a = 32'h00001FFF;
            5'd18:   a = 32'h00000FFF;
            5'd19:   a = 32'h000007FF;
            default: a = '0;
        endcase
        return W'(a >> SH);
    endfunction

    state_t state_q, state_d;

    logic signed [W-1:0] x_q, y_q, z_q;
    logic        [4:0]   cnt_q;
    logic                valid_q, sign_q, int_q;
    logic        [18:0]  frac_q;

    logic signed [W-1:0]   x_sh, y_sh, atan_v, x_n, y_n, z_n, x_fin;
    logic signed [2*W-1:0] zy;
    logic                  d_neg;
    logic        [W-1:0]   mag;
    logic        [W:0]     rsum;
    logic                  sat_c, zero_c, sign_c;
    logic        [18:0]    frac_c;

    always_comb begin
        d_neg  = z_q[W-1];
        x_sh   = x_q >>> cnt_q;
        y_sh   = y_q >>> cnt_q;
        atan_v = signed'(atan_w(cnt_q));
        x_n    = d_neg ? (x_q + y_sh) : (x_q - y_sh);
        y_n    = d_neg ? (y_q - x_sh) : (y_q + x_sh);
        z_n    = d_neg ? (z_q + atan_v) : (z_q - atan_v);
    end

    // Fold the leftover angle into x (cos(a-z) ~ x - z*y) so accuracy reaches ~2^-19 at 16 iterations.
    always_comb begin
        zy     = z_q * y_q;
        x_fin  = x_q - W'(zy >>> (W - 2));
        mag    = x_fin[W-1] ? -x_fin : x_fin;
        rsum   = {1'b0, mag} + HALF;
        sat_c  = (rsum >> (W - 2)) != '0;
        zero_c = (rsum >> D) == '0;
        frac_c = sat_c ? 19'd0 : 19'(rsum >> D);
        sign_c = x_fin[W-1] & ~zero_c;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (valid_i)          state_d = ROTATE;
            ROTATE:  if (cnt_q == ITER_C)  state_d = DONE;
            DONE:    if (ready_i)          state_d = IDLE;
            default:                       state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            sign_q  <= 1'b0;
            int_q   <= 1'b0;
            frac_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (valid_i) begin
                        x_q   <= signed'(K_W);
                        y_q   <= '0;
                        z_q   <= signed'({{(W - 22){angle_i[21]}}, angle_i} << (W - 22));
                        cnt_q <= '0;
                    end
                end
                ROTATE: begin
                    if (cnt_q == ITER_C) begin
                        valid_q <= 1'b1;
                        sign_q  <= sign_c;
                        int_q   <= sat_c;
                        frac_q  <= frac_c;
                    end else begin
                        x_q   <= x_n;
                        y_q   <= y_n;
                        z_q   <= z_n;
                        cnt_q <= cnt_q + 5'd1;
                    end
                end
                DONE: begin
                    if (ready_i) valid_q <= 1'b0;
                end
                default: valid_q <= 1'b0;
            endcase
        end
    end

    assign ready_o      = rst_ni & (state_q == IDLE);
    assign valid_o      = valid_q;
    assign sign_o       = sign_q;
    assign integer_o    = int_q;
    assign fractional_o = frac_q;

endmodule

// File: tb/tb_cordic_cos_fixed.sv
// Directed bench for cordic_cos_fixed: reset, latency, backpressure, known cosines,
// mid-operation reset and a back-to-back sweep against $cos.
module tb_cordic_cos_fixed;

    logic        clk_i = 1'b0;
    logic        rst_ni, valid_i, ready_i;
    logic        ready_o, valid_o, sign_o, integer_o;
    logic [21:0] angle_i;
    logic [18:0] fractional_o;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk_i = ~clk_i;

    cordic_cos_fixed #(.ITER(16), .W(24)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .angle_i      (angle_i),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .sign_o       (sign_o),
        .integer_o    (integer_o),
        .fractional_o (fractional_o)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_near(input string tag, input int obs, input int exp, input int tol);
        n_total++;
        assert ((obs >= exp - tol) && (obs <= exp + tol)) begin
            n_pass++;
        end else begin
            $error("FAIL %s: got %0d, expected %0d +/- %0d", tag, obs, exp, tol);
        end
    endtask

    // Accept one angle, wait (bounded) for the result, consume it.
    task automatic do_op(input string tag, input logic [21:0] a, output int res, output int sgn);
        int lat;
        @(negedge clk_i);
        valid_i = 1'b1;
        angle_i = a;
        ready_i = 1'b0;
        @(negedge clk_i);
        angle_i = ~a;
        lat = 0;
        while (valid_o !== 1'b1 && lat < 40) begin
            @(negedge clk_i);
            lat++;
        end
        valid_i = 1'b0;
        chk({tag, "_latency"}, lat, 17);
        res = int'({integer_o, fractional_o});
        sgn = int'(sign_o);
        ready_i = 1'b1;
        @(negedge clk_i);
        ready_i = 1'b0;
        chk({tag, "_consumed"}, int'(valid_o), 0);
    endtask

    initial begin
        int res, sgn, lat, seen, snap;
        logic [21:0] q[$];
        logic [21:0] a;
        int next_k, got, cyc, last_t, min_gap, max_gap, ai, obs;
        real expv, diff;

        rst_ni  = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b0;
        angle_i = '0;
        repeat (2) @(negedge clk_i);
        chk("in_reset_ready", int'(ready_o), 0);
        chk("in_reset_valid", int'(valid_o), 0);
        rst_ni = 1'b1;
        #1;
        chk("rst_ready", int'(ready_o), 1);
        chk("rst_valid", int'(valid_o), 0);
        chk("rst_out", int'({sign_o, integer_o, fractional_o}), 0);

        // angle 0 -> exactly 1.0, then hold backpressure with a competing valid_i
        @(negedge clk_i);
        valid_i = 1'b1;
        angle_i = 22'h000000;
        @(negedge clk_i);
        chk("busy_after_accept", int'(ready_o), 0);
        angle_i = 22'h080000;
        lat = 0;
        while (valid_o !== 1'b1 && lat < 40) begin
            @(negedge clk_i);
            lat++;
        end
        chk("zero_latency", lat, 17);
        chk("zero_sign", int'(sign_o), 0);
        chk("zero_int", int'(integer_o), 1);
        chk("zero_frac", int'(fractional_o), 0);
        snap = int'({sign_o, integer_o, fractional_o});
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            chk("bp_valid", int'(valid_o), 1);
            chk("bp_ready", int'(ready_o), 0);
            chk("bp_data", int'({sign_o, integer_o, fractional_o}), snap);
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        @(negedge clk_i);
        ready_i = 1'b0;
        chk("bp_consume_valid", int'(valid_o), 0);
        chk("bp_consume_ready", int'(ready_o), 1);
        repeat (20) @(negedge clk_i);
        chk("bp_no_phantom", int'(valid_o), 0);

        do_op("pos_half", 22'h080000, res, sgn);
        chk_near("pos_half_val", res, 460106, 2);
        chk("pos_half_sign", sgn, 0);
        do_op("neg_half", 22'h380000, res, sgn);
        chk_near("neg_half_val", res, 460106, 2);
        chk("neg_half_sign", sgn, 0);
        do_op("neg_one", 22'h300000, res, sgn);
        chk_near("neg_one_val", res, 283274, 2);
        chk("neg_one_sign", sgn, 0);
        do_op("pos_one", 22'h100000, res, sgn);
        chk_near("pos_one_val", res, 283274, 2);
        chk("pos_one_sign", sgn, 0);
        do_op("out_of_range", 22'h1FFFFF, res, sgn);

        // reset while iteration 7 is pending
        @(negedge clk_i);
        valid_i = 1'b1;
        angle_i = 22'h080000;
        @(negedge clk_i);
        valid_i = 1'b0;
        repeat (7) @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        chk("midrst_valid", int'(valid_o), 0);
        chk("midrst_ready", int'(ready_o), 0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        chk("midrst_rel_ready", int'(ready_o), 1);
        chk("midrst_rel_out", int'({sign_o, integer_o, fractional_o}), 0);
        ready_i = 1'b1;
        seen = 0;
        repeat (30) begin
            @(negedge clk_i);
            if (valid_o === 1'b1) seen++;
        end
        ready_i = 1'b0;
        chk("midrst_no_stale", seen, 0);
        do_op("recover", 22'h000000, res, sgn);
        chk("recover_val", res, 524288);

        // back-to-back sweep of [-1, 1) against $cos
        ready_i = 1'b1;
        next_k  = 0;
        got     = 0;
        cyc     = 0;
        last_t  = -1;
        min_gap = 1000;
        max_gap = 0;
        while (got < 2048 && cyc < 2048 * 19 + 200) begin
            if (valid_o === 1'b1 && q.size() > 0) begin
                a    = q.pop_front();
                ai   = int'(signed'(a));
                expv = $cos($itor(ai) / 1048576.0) * 524288.0;
                obs  = int'({integer_o, fractional_o});
                if (sign_o) obs = -obs;
                diff = $itor(obs) - expv;
                n_total++;
                assert ((diff <= 2.0) && (diff >= -2.0)) begin
                    n_pass++;
                end else begin
                    $error("FAIL sweep angle=%0d: got %0d, expected %0f", ai, obs, expv);
                end
                if (last_t >= 0) begin
                    if (cyc - last_t < min_gap) min_gap = cyc - last_t;
                    if (cyc - last_t > max_gap) max_gap = cyc - last_t;
                end
                last_t = cyc;
                got++;
            end
            if (ready_o === 1'b1) begin
                if (next_k < 2048) begin
                    a = 22'(-1048576 + next_k * 1024);
                    angle_i = a;
                    valid_i = 1'b1;
                    q.push_back(a);
                    next_k++;
                end else begin
                    valid_i = 1'b0;
                end
            end
            @(negedge clk_i);
            cyc++;
        end
        valid_i = 1'b0;
        ready_i = 1'b0;
        chk("sweep_count", got, 2048);
        chk("sweep_min_gap", min_gap, 19);
        chk("sweep_max_gap", max_gap, 19);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
